// File: rtl/spu_hazard_ctrl.sv
// rtl/spu_hazard_ctrl.sv - SPU pipeline hazard controller: forwarding selects, load-use, long-op and flush sequencing
//
// Tracks the destination of every in-flight instruction (EX and MEM slots)
// and produces registered EX-stage forwarding selects plus the stall/bubble/
// flush controls for the ID and ID/EX stages.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_valid                      ID holds a real instruction
//   id_ra/id_rb/id_rc             source register addresses
//   id_use_a/id_use_b/id_use_c    source actually read
//   id_rt, id_wr                  destination register and write enable
//   id_load, id_long              load / long-latency instruction in ID
//   ex_br_taken                   taken branch resolved in EX (one cycle)
//   stall_id                      hold PC and IF/ID (combinational)
//   flush_ifid                    invalidate IF/ID (combinational)
//   ex_hold                       hold ID/EX, long op executing (registered)
//   ex_bubble                     load a bubble into ID/EX (combinational)
//   ReadData{1,2,3}Sel_EX         operand A/B/C select: 00 RF, 01 MEM, 10 WB

module spu_hazard_ctrl #(
    parameter int REG_W    = 7,
    parameter int LONG_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic [REG_W-1:0] id_rc,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             id_use_c,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_long,
    input  logic             ex_br_taken,
    output logic             stall_id,
    output logic             flush_ifid,
    output logic             ex_hold,
    output logic             ex_bubble,
    output logic [1:0]       ReadData1Sel_EX,
    output logic [1:0]       ReadData2Sel_EX,
    output logic [1:0]       ReadData3Sel_EX
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(LONG_LAT - 1);

    // Slots keep only what is ever compared: valid&wr folded into a single
    // write-enable, load only for the EX slot. A WB-slot producer has already
    // written the write-through RF, so nothing beyond MEM needs tracking.
    logic             r_ex_wen;
    logic             r_ex_load;
    logic [REG_W-1:0] r_ex_rt;
    logic             r_mem_wen;
    logic [REG_W-1:0] r_mem_rt;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_ex_hold;
    logic [1:0]       r_sel_a;
    logic [1:0]       r_sel_b;
    logic [1:0]       r_sel_c;

    logic w_hit_ex_a, w_hit_ex_b, w_hit_ex_c;
    logic w_hit_mem_a, w_hit_mem_b, w_hit_mem_c;
    logic [1:0] w_sel_a, w_sel_b, w_sel_c;
    logic w_busy;
    logic w_load_use;
    logic w_issue;

    assign w_hit_ex_a  = id_use_a & r_ex_wen  & (r_ex_rt  == id_ra);
    assign w_hit_ex_b  = id_use_b & r_ex_wen  & (r_ex_rt  == id_rb);
    assign w_hit_ex_c  = id_use_c & r_ex_wen  & (r_ex_rt  == id_rc);
    assign w_hit_mem_a = id_use_a & r_mem_wen & (r_mem_rt == id_ra);
    assign w_hit_mem_b = id_use_b & r_mem_wen & (r_mem_rt == id_rb);
    assign w_hit_mem_c = id_use_c & r_mem_wen & (r_mem_rt == id_rc);

    // Nearest producer wins: the EX-slot producer will sit in MEM next cycle.
    assign w_sel_a = w_hit_ex_a ? 2'b01 : (w_hit_mem_a ? 2'b10 : 2'b00);
    assign w_sel_b = w_hit_ex_b ? 2'b01 : (w_hit_mem_b ? 2'b10 : 2'b00);
    assign w_sel_c = w_hit_ex_c ? 2'b01 : (w_hit_mem_c ? 2'b10 : 2'b00);

    assign w_busy     = (r_state == ST_BUSY);
    assign w_load_use = id_valid & r_ex_load & (w_hit_ex_a | w_hit_ex_b | w_hit_ex_c);
    assign w_issue    = ~w_busy & id_valid & ~ex_br_taken & ~w_load_use;

    // Flush lets the fetch redirect proceed even over a load-use hazard.
    assign stall_id   = w_busy | (~ex_br_taken & w_load_use);
    assign ex_bubble  = ~w_busy & (ex_br_taken | w_load_use);
    assign flush_ifid = ex_br_taken;

    assign ex_hold         = r_ex_hold;
    assign ReadData1Sel_EX = r_sel_a;
    assign ReadData2Sel_EX = r_sel_b;
    assign ReadData3Sel_EX = r_sel_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_wen  <= 1'b0;
            r_ex_load <= 1'b0;
            r_ex_rt   <= '0;
            r_mem_wen <= 1'b0;
            r_mem_rt  <= '0;
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_ex_hold <= 1'b0;
            r_sel_a   <= 2'b00;
            r_sel_b   <= 2'b00;
            r_sel_c   <= 2'b00;
        end else if (w_busy) begin
            // Long op frozen in EX; MEM drains to bubbles, selects hold.
            r_mem_wen <= 1'b0;
            r_cnt     <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_state   <= ST_IDLE;
                r_ex_hold <= 1'b0;
            end
        end else begin
            r_mem_wen <= r_ex_wen;
            r_mem_rt  <= r_ex_rt;
            r_ex_wen  <= w_issue & id_wr;
            r_ex_load <= w_issue & id_load;
            r_ex_rt   <= id_rt;
            r_sel_a   <= w_issue ? w_sel_a : 2'b00;
            r_sel_b   <= w_issue ? w_sel_b : 2'b00;
            r_sel_c   <= w_issue ? w_sel_c : 2'b00;
            if (w_issue & id_long) begin
                r_state   <= ST_BUSY;
                r_cnt     <= LP_CNT_INIT;
                r_ex_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spu_hazard_ctrl.sv
// tb/tb_spu_hazard_ctrl.sv - self-checking bench for spu_hazard_ctrl
module tb_spu_hazard_ctrl;

    localparam int REG_W    = 7;
    localparam int LONG_LAT = 4;

    logic clk;
    logic rst_n;
    logic id_valid, id_use_a, id_use_b, id_use_c, id_wr, id_load, id_long, ex_br_taken;
    logic [REG_W-1:0] id_ra, id_rb, id_rc, id_rt;
    logic stall_id, flush_ifid, ex_hold, ex_bubble;
    logic [1:0] sel1, sel2, sel3;

    spu_hazard_ctrl #(.REG_W(REG_W), .LONG_LAT(LONG_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_ra(id_ra), .id_rb(id_rb), .id_rc(id_rc),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_c(id_use_c),
        .id_rt(id_rt), .id_wr(id_wr), .id_load(id_load), .id_long(id_long),
        .ex_br_taken(ex_br_taken), .stall_id(stall_id), .flush_ifid(flush_ifid),
        .ex_hold(ex_hold), .ex_bubble(ex_bubble),
        .ReadData1Sel_EX(sel1), .ReadData2Sel_EX(sel2), .ReadData3Sel_EX(sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v; int ra, rb, rc; bit ua, ub, uc; int rt; bit wr, ld, lg, br;
        bit e_stall, e_bub, e_flush, e_hold; int s1, s2, s3;
    } vec_t;

    typedef struct { bit v, wr, ld; int rt; } minst_t;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: instructions in EX (0) and MEM (1), plus how many more
    // edges the EX instruction stays in EX.
    minst_t mp[2];
    int     m_left;
    int     m_sel[3];

    function automatic vec_t row(bit v, int ra, int rb, int rc, bit ua, bit ub, bit uc,
                                 int rt, bit wr, bit ld, bit lg, bit br,
                                 bit st, bit bu, bit fl, bit ho, int s1, int s2, int s3);
        vec_t r;
        r.v = v; r.ra = ra; r.rb = rb; r.rc = rc; r.ua = ua; r.ub = ub; r.uc = uc;
        r.rt = rt; r.wr = wr; r.ld = ld; r.lg = lg; r.br = br;
        r.e_stall = st; r.e_bub = bu; r.e_flush = fl; r.e_hold = ho;
        r.s1 = s1; r.s2 = s2; r.s3 = s3;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.v; id_ra = REG_W'(v.ra); id_rb = REG_W'(v.rb); id_rc = REG_W'(v.rc);
        id_use_a = v.ua; id_use_b = v.ub; id_use_c = v.uc;
        id_rt = REG_W'(v.rt); id_wr = v.wr; id_load = v.ld; id_long = v.lg;
        ex_br_taken = v.br;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, " stall_id"},   int'(stall_id),   int'(v.e_stall));
        check({tag, " ex_bubble"},  int'(ex_bubble),  int'(v.e_bub));
        check({tag, " flush_ifid"}, int'(flush_ifid), int'(v.e_flush));
        @(posedge clk);
        #1;
        check({tag, " ex_hold"}, int'(ex_hold), int'(v.e_hold));
        check({tag, " sel1"},    int'(sel1),    v.s1);
        check({tag, " sel2"},    int'(sel2),    v.s2);
        check({tag, " sel3"},    int'(sel3),    v.s3);
    endtask

    function automatic int nearest(int r, bit u);
        if (!u) return 0;
        for (int d = 0; d < 2; d++)
            if (mp[d].v && mp[d].wr && mp[d].rt == r) return d + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) mp[d] = '{0, 0, 0, 0};
        m_left = 0;
        for (int k = 0; k < 3; k++) m_sel[k] = 0;
    endtask

    // Fills the expected fields of v from the model and advances the model.
    task automatic model_step(inout vec_t v);
        bit busy, lu, iss;
        int na, nb, nc;
        busy = (m_left > 0);
        na = nearest(v.ra, v.ua); nb = nearest(v.rb, v.ub); nc = nearest(v.rc, v.uc);
        lu = v.v && mp[0].ld && (na == 1 || nb == 1 || nc == 1);
        v.e_stall = busy || (!v.br && lu);
        v.e_bub   = !busy && (v.br || lu);
        v.e_flush = v.br;
        if (busy) begin
            mp[1]  = '{0, 0, 0, 0};
            m_left = m_left - 1;
        end else begin
            iss   = v.v && !v.br && !lu;
            mp[1] = mp[0];
            mp[0] = iss ? minst_t'{1, v.wr, v.ld, v.rt} : minst_t'{0, 0, 0, 0};
            m_sel[0] = iss ? na : 0;
            m_sel[1] = iss ? nb : 0;
            m_sel[2] = iss ? nc : 0;
            m_left   = (iss && v.lg) ? LONG_LAT - 1 : 0;
        end
        v.e_hold = (m_left > 0);
        v.s1 = m_sel[0]; v.s2 = m_sel[1]; v.s3 = m_sel[2];
    endtask

    vec_t tbl[19];
    vec_t rv;

    initial begin
        // Directed table (LONG_LAT = 4).
        tbl[0]  = row(1, 1, 2, 0, 1,1,0,  5, 1,0,0,0, 0,0,0,0, 0,0,0);
        tbl[1]  = row(1, 5, 3, 0, 1,1,0,  6, 1,0,0,0, 0,0,0,0, 1,0,0); // distance 1
        tbl[2]  = row(1, 6, 5, 0, 1,1,0, 21, 1,0,0,0, 0,0,0,0, 1,2,0); // dist 1 on A, 2 on B
        tbl[3]  = row(1,20, 5, 0, 1,1,0, 22, 1,0,0,0, 0,0,0,0, 0,0,0); // distance 3
        tbl[4]  = row(1,30, 0, 0, 1,0,0,  9, 1,1,0,0, 0,0,0,0, 0,0,0); // load r9
        tbl[5]  = row(1, 1, 2, 9, 0,0,1, 23, 1,0,0,0, 1,1,0,0, 0,0,0); // load-use stall
        tbl[6]  = row(1, 1, 2, 9, 0,0,1, 23, 1,0,0,0, 0,0,0,0, 0,0,2); // re-issue, WB fwd
        tbl[7]  = row(1,23, 0, 0, 1,0,0,  7, 1,0,1,0, 0,0,0,1, 1,0,0); // long r7
        tbl[8]  = row(1, 7, 0, 0, 1,0,0, 24, 1,0,0,0, 1,0,0,1, 1,0,0);
        tbl[9]  = row(1, 7, 0, 0, 1,0,0, 24, 1,0,0,0, 1,0,0,1, 1,0,0);
        tbl[10] = row(1, 7, 0, 0, 1,0,0, 24, 1,0,0,0, 1,0,0,0, 1,0,0);
        tbl[11] = row(1, 7, 0, 0, 1,0,0, 24, 1,0,0,0, 0,0,0,0, 1,0,0); // reader issues
        tbl[12] = row(1, 0, 0, 0, 0,0,0, 40, 1,1,0,0, 0,0,0,0, 0,0,0); // load r40
        tbl[13] = row(1, 0, 0,40, 0,0,1, 41, 1,0,0,1, 0,1,1,0, 0,0,0); // flush over load-use
        tbl[14] = row(1,41,40, 0, 1,1,0, 42, 1,0,0,0, 0,0,0,0, 0,2,0); // r41 never tracked
        tbl[15] = row(0,42, 0, 0, 1,0,0, 43, 1,0,0,0, 0,0,0,0, 0,0,0); // invalid ID
        tbl[16] = row(1, 1, 2, 0, 1,1,0, 50, 1,0,0,0, 0,0,0,0, 0,0,0);
        tbl[17] = row(1,50, 0, 0, 1,0,0, 51, 1,0,1,0, 0,0,0,1, 1,0,0); // long r51
        tbl[18] = row(1,51, 0, 0, 1,0,0, 52, 1,0,0,0, 1,0,0,1, 1,0,0); // BUSY cycle 1

        rst_n = 1'b0;
        drive(row(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0));
        repeat (2) @(posedge clk);
        #1;
        check("reset ex_hold",   int'(ex_hold),   0);
        check("reset stall_id",  int'(stall_id),  0);
        check("reset ex_bubble", int'(ex_bubble), 0);
        check("reset sel1",      int'(sel1),      0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("row%0d", i));

        // Reset asserted in BUSY cycle 2 aborts the long op asynchronously.
        @(negedge clk);
        drive(tbl[18]);
        #1;
        check("busy2 stall_id", int'(stall_id), 1);
        rst_n = 1'b0;
        #1;
        check("async ex_hold",  int'(ex_hold),  0);
        check("async sel1",     int'(sel1),     0);
        check("async stall_id", int'(stall_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(row(1,51,0,0,1,0,0,53,1,0,0,0, 0,0,0,0, 0,0,0), "post-reset");

        // Randomized run against the reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            rv.v  = ($urandom_range(0, 9) != 0);
            rv.ra = $urandom_range(0, 5); rv.rb = $urandom_range(0, 5); rv.rc = $urandom_range(0, 5);
            rv.ua = $urandom_range(0, 1); rv.ub = $urandom_range(0, 1); rv.uc = $urandom_range(0, 1);
            rv.rt = $urandom_range(0, 5);
            rv.wr = ($urandom_range(0, 5) != 0);
            rv.ld = ($urandom_range(0, 3) == 0);
            rv.lg = !rv.ld && ($urandom_range(0, 9) == 0);
            rv.br = (m_left == 0) && ($urandom_range(0, 9) == 0);
            model_step(rv);
            run_vec(rv, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spu_hazard_ctrl.md
# spu_hazard_ctrl

Pipeline hazard controller for the SPU integer pipeline (ID → EX → MEM → WB). It tracks the destination register of every in-flight instruction. It produces the registered 2-bit operand-forwarding selects that drive the EX-stage operand muxes (RF / ALUResult_MEM / ALUResult_WB), and it sequences pipeline stalls for load-use hazards, multi-cycle EX operations and taken-branch flushes. It sits beside the ID/EX pipeline register; all state lives here, not in the stages.

## Interface
Parameters:
- REG_W, 7, register-address width (128 registers)
- LONG_LAT, 4, EX occupancy in cycles of a long-latency op (legal range 2..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ra, id_rb, id_rc  in  REG_W each  source register addresses
- id_use_a, id_use_b, id_use_c  in  1 each  source actually read
- id_rt  in  REG_W  destination register (RT/RRR already selected)
- id_wr  in  1  instruction writes id_rt
- id_load  in  1  instruction is a load (result usable only from WB)
- id_long  in  1  instruction occupies EX for LONG_LAT cycles
- ex_br_taken  in  1  branch in EX resolved taken (qualified, one cycle)
- stall_id  out  1  hold PC and IF/ID register (combinational)
- flush_ifid  out  1  invalidate IF/ID (combinational, = ex_br_taken)
- ex_hold  out  1  hold ID/EX register contents, long op still executing (registered)
- ex_bubble  out  1  load a bubble into ID/EX this edge (combinational)
- ReadData1Sel_EX, ReadData2Sel_EX, ReadData3Sel_EX  out  2 each  forwarding selects for operands A/B/C, registered: 00 RF, 01 MEM, 10 WB, 11 never driven

## Operation
- Tracker: three slots EX, MEM, WB, each {valid, wr, load, rt}. Per non-held edge: WB←MEM, MEM←EX, EX←issued ID instruction or bubble.
- Source hit: operand X hits slot S when id_use_X & S.valid & S.wr & (S.rt == id_rX).
- Select computed in ID, registered into *Sel_EX on issue:
  - EX-slot hit → 01 (producer will be in MEM)
  - else MEM-slot hit → 10 (producer will be in WB)
  - else → 00 (a WB-slot producer is already written; RF is write-through)
  - nearest producer wins
- Load-use: an EX-slot hit where EX.load = 1 forces stall_id = 1 and ex_bubble = 1 for one cycle. The next cycle re-evaluates: the load is then in MEM and the select becomes 10.
- Long-op FSM, states IDLE and BUSY, 4-bit counter cnt:
  - IDLE → BUSY when an id_long instruction issues; cnt ← LONG_LAT-1.
  - In BUSY: ex_hold = 1, stall_id = 1; EX slot frozen; MEM slot receives a bubble each edge; WB keeps advancing; cnt decrements.
  - BUSY → IDLE on the edge where cnt = 1. The op then advances to MEM on the following edge.
- Flush: ex_br_taken = 1 kills the ID instruction. It is not issued (ex_bubble = 1), flush_ifid = 1, and stall_id = 0 so the fetch redirect proceeds. Flush overrides load-use stall.
- Priority: BUSY > flush > load-use > normal issue. ex_br_taken while BUSY cannot occur, since a branch is never long; it is ignored.
- id_valid = 0 issues a bubble: selects ← 00, slot invalid.
- Selects hold their value while ex_hold = 1 and become 00 on a bubble.

## Timing
- Reset (async, rst_n = 0): all slots invalid, FSM IDLE, cnt = 0, all *Sel_EX = 00, ex_hold = 0. Combinational outputs follow: stall_id = 0, ex_bubble = 0 unless inputs demand otherwise. Reset mid-BUSY aborts the op immediately.
- Forwarding selects are valid in the cycle the instruction is in EX, i.e. one edge after its ID cycle.
- Load-use costs exactly 1 cycle. A long op costs LONG_LAT-1 stall cycles.
- stall_id, ex_bubble and flush_ifid are combinational from ID inputs and tracker state; no path through them into the tracker within the same cycle.

## Test plan
- Back-to-back ALU: r5 ← r1+r2, then r6 ← r5+r3 → second instruction in EX has ReadData1Sel_EX = 01, no stall.
- Distance 2: r5 written, one unrelated instruction, then a reader of r5 in operand B → ReadData2Sel_EX = 10. Distance 3 → 00.
- Load-use: load r9, then add reads r9 on C → stall_id = 1 and ex_bubble = 1 for exactly one cycle; then ReadData3Sel_EX = 10.
- Long op, LONG_LAT = 4: issue long r7; next instruction reads r7 → stall_id and ex_hold high for 3 cycles; reader then sees select 01.
- Taken branch while the ID instruction has a load-use hazard → flush_ifid = 1, stall_id = 0, ex_bubble = 1; the killed instruction never appears in the tracker.
- rst_n pulled low in cycle 2 of BUSY → ex_hold = 0 and all selects 00 asynchronously; after release, a normal instruction issues with no residual stall.
